ook_demodulator: RTL and testbench
==================================

OOK_DEMODULATOR -- requirements
Module: ook_demodulator

Interface
REQ-001 SHALL provide parameter PERIOD_W, default 16, the width of cycles_per_half_period.
REQ-002 SHALL provide parameter TOL, default 2, the allowed carrier-period deviation in clk cycles.
REQ-003 SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-004 SHALL have port n_reset, input, 1 bit: the reset, synchronous and active-low.
REQ-005 SHALL have port in, input, 1 bit: the asynchronous on-off-keyed signal returning from the delay line.
REQ-006 SHALL have port cycles_per_half_period, input, PERIOD_W bits: H, the same value the transmit modulator uses.
REQ-007 SHALL have port out, output, 1 bit: the recovered data, 1 while a carrier is present.
REQ-008 SHALL have port period_err, output, 1 bit: a one-cycle pulse on each out-of-window carrier edge.
REQ-009 SHALL have port last_period, output, PERIOD_W+2 bits: the most recently measured rise-to-rise interval.

Function
REQ-010 SHALL pass in through a two-flop synchronizer (s1, s2) plus a delay flop s3, and SHALL define rise = s2 AND NOT s3.
REQ-011 SHALL define the expected carrier period P_exp = 2*(H+1) cycles, computed PERIOD_W+2 bits wide, matching the modulator half-period of H+1 cycles.
REQ-012 SHALL define the acceptance window as lo = max(P_exp-TOL, 1) and hi = P_exp+TOL, with no wrap on subtraction.
REQ-013 SHALL keep an interval counter ctr (PERIOD_W+2 bits) that loads 1 on rise, otherwise increments, and saturates at all-ones without wrapping.
REQ-014 SHALL measure the interval P at each rise as the current ctr value, SHALL load last_period with P on every rise, and SHALL consider P valid only if a previous rise has occurred since IDLE.
REQ-015 SHALL implement a state machine with states IDLE, ACQUIRE and LOCKED, and SHALL drive out = 1 only in LOCKED.
REQ-016 SHALL, in IDLE, go to ACQUIRE on rise (no interval is checked on this first edge).
REQ-017 SHALL, in ACQUIRE: on rise with lo<=P<=hi go to LOCKED; on rise with P outside the window stay in ACQUIRE and pulse period_err.
REQ-018 SHALL, in LOCKED: on rise with lo<=P<=hi stay in LOCKED; on rise with P outside the window go to ACQUIRE and pulse period_err.
REQ-019 SHALL, in ACQUIRE or LOCKED with no rise in the cycle and ctr > hi (timeout), go to IDLE with no period_err.
REQ-020 SHALL give rise priority over timeout when both occur in the same cycle.
REQ-021 SHALL register out and SHALL assert it on the clk edge after the qualifying rise cycle, i.e. 3 clk edges after in is first sampled high.
REQ-022 SHALL register period_err, asserted for exactly one cycle.
REQ-023 SHALL apply a change of cycles_per_half_period to the next comparison, with no flush of state.
REQ-024 SHALL treat H=0 as legal (P_exp=2).
REQ-025 SHALL treat H at its maximum as legal, with no overflow of P_exp or hi.

Reset
REQ-026 SHALL, while n_reset=0 at a clk edge: set state to IDLE; clear s1, s2, s3, ctr and last_period to 0; drive out=0 and period_err=0.
REQ-027 SHALL, when reset is asserted mid-operation, abandon the lock immediately, and SHALL require a fresh IDLE->ACQUIRE->LOCKED sequence after release.

Configuration
REQ-028 SHALL, with OOK_DEMOD_PERIOD_CHECK_EN defined, apply the window checks of REQ-017 and REQ-018.
REQ-029 SHALL, without OOK_DEMOD_PERIOD_CHECK_EN: treat every rise in ACQUIRE as moving to LOCKED; treat every rise in LOCKED as staying in LOCKED; tie period_err to 0; keep the REQ-019 timeout and last_period unchanged.

Verification
REQ-030 SHALL cover reset: n_reset=0 for 3 cycles with in toggling -> out=0, period_err=0, last_period=0 throughout and on the first cycle after release.
REQ-031 SHALL cover lock: H=4, TOL=2, in 5 cycles high / 5 cycles low -> out=1 after the second synchronized rise, last_period=10, period_err never asserted.
REQ-032 SHALL cover burst end: from LOCKED, in held 0 -> out falls on the edge after ctr exceeds 12, with no period_err.
REQ-033 SHALL cover a bad spacing: from LOCKED, rises spaced 6 cycles (macro defined) -> one period_err pulse, out=0 (ACQUIRE), last_period=6; then two rises spaced 10 -> out=1.
REQ-034 SHALL cover the macro undefined: rises spaced 6 cycles -> out=1 after the second rise, period_err stays 0; in held 0 -> timeout to IDLE.
REQ-035 SHALL cover reset mid-lock: n_reset=0 for 1 cycle while LOCKED -> out=0 next cycle, and two valid rises are needed to reassert out.

Source files
------------

// File: rtl/ook_demodulator.sv
// ook_demodulator
//   Recovers on-off-keyed data from a carrier that returns from the delay line.
//   The input is synchronized and its rising edges are timestamped with an
//   interval counter. Two consecutive rises spaced close to the expected carrier
//   period lock the receiver, and out is 1 while the receiver is locked. When no
//   edge arrives within the acceptance window, the receiver falls back to IDLE.
//
//   Build option: define OOK_DEMOD_PERIOD_CHECK_EN to enable the rise-to-rise
//   window check. Without it, any rise advances the lock and period_err stays 0.
//   The timeout is active in both builds.
//
// Ports
//   clk                    in   clock, rising edge
//   n_reset                in   synchronous active-low reset
//   in                     in   asynchronous OOK input
//   cycles_per_half_period in   H; the carrier half-period is H+1 clk cycles
//   out                    out  recovered data (1 while locked)
//   period_err             out  one-cycle pulse on an out-of-window carrier edge
//   last_period            out  most recent rise-to-rise interval in clk cycles
module ook_demodulator #(
    parameter int PERIOD_W = 16,
    parameter int TOL      = 2
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                in,
    input  logic [PERIOD_W-1:0] cycles_per_half_period,
    output logic                out,
    output logic                period_err,
    output logic [PERIOD_W+1:0] last_period
);

    // Two extra bits hold 2*(H+1)+TOL without overflow, even at the maximum H.
    localparam int CW = PERIOD_W + 2;
    localparam logic [CW-1:0] TOL_C = CW'(TOL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic [CW-1:0] ctr;
    logic [CW-1:0] p_exp;
    logic [CW-1:0] hi;
    logic          rise;
    logic          in_window;
    logic          timeout;

    assign rise    = s2 & ~s3;
    assign p_exp   = ({2'b00, cycles_per_half_period} + CW'(1)) << 1;
    assign hi      = p_exp + TOL_C;
    assign timeout = (ctr > hi);

`ifdef OOK_DEMOD_PERIOD_CHECK_EN
    logic [CW-1:0] lo;
    // Clamp the lower bound at 1 so that a small P_exp cannot wrap.
    assign lo        = (p_exp > TOL_C) ? (p_exp - TOL_C) : CW'(1);
    assign in_window = (ctr >= lo) && (ctr <= hi);
`else
    assign in_window = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state       <= IDLE;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            ctr         <= '0;
            last_period <= '0;
            out         <= 1'b0;
            period_err  <= 1'b0;
        end else begin
            s1         <= in;
            s2         <= s1;
            s3         <= s2;
            period_err <= 1'b0;

            // ctr holds the number of cycles since the last rise, so its
            // value on the next rise is the rise-to-rise interval.
            if (rise) begin
                ctr         <= CW'(1);
                last_period <= ctr;
            end else if (ctr != {CW{1'b1}}) begin
                ctr <= ctr + CW'(1);
            end

            // A rise takes priority over a timeout in the same cycle.
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (rise) begin
                        if (in_window) begin
                            state <= LOCKED;
                            out   <= 1'b1;
                        end else begin
                            period_err <= 1'b1;
                        end
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        if (!in_window) begin
                            state      <= ACQUIRE;
                            out        <= 1'b0;
                            period_err <= 1'b1;
                        end
                    end else if (timeout) begin
                        state <= IDLE;
                        out   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ook_demodulator.sv
// tb_ook_demodulator
//   Drives single-cycle input pulses at chosen spacings. Expected out,
//   period_err and last_period values are queued with the cycle at which they
//   must appear. When in goes high at cycle k, the qualifying rise is
//   registered at edge k+3. A narrow PERIOD_W keeps the maximum-H case and
//   counter saturation short enough to simulate.
module tb_ook_demodulator;

`ifdef OOK_DEMOD_PERIOD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_reset;
    logic       din;
    logic [3:0] h;
    logic       out;
    logic       period_err;
    logic [5:0] last_period;

    ook_demodulator #(.PERIOD_W(4), .TOL(2)) dut (
        .clk                    (clk),
        .n_reset                (n_reset),
        .in                     (din),
        .cycles_per_half_period (h),
        .out                    (out),
        .period_err             (period_err),
        .last_period            (last_period)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      name;
        logic       exp_out;
        logic       exp_err;
        logic       chk_last;
        logic [5:0] exp_last;
    } exp_t;

    typedef struct {
        string      name;
        int         h;
        int         sp;
        logic       out_en;
        logic       err_en;
        logic       out_dis;
        logic [5:0] last;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[11];
    int   errors   = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   err_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (period_err === 1'b1) err_seen++;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, ".out"}, 32'(out), 32'(e.exp_out));
            chk({e.name, ".err"}, 32'(period_err), 32'(e.exp_err));
            if (e.chk_last) chk({e.name, ".last"}, 32'(last_period), 32'(e.exp_last));
        end
    endtask

    task automatic expect_at(input int at, input string name, input logic o,
                             input logic er, input logic cl, input logic [5:0] l);
        exp_t e;
        e.cyc = at; e.name = name; e.exp_out = o; e.exp_err = er;
        e.chk_last = cl; e.exp_last = l;
        sbq.push_back(e);
    endtask

    task automatic gap(input int n);
        din = 1'b1;
        step();
        din = 1'b0;
        repeat (n - 1) step();
    endtask

    task automatic reset_dut();
        n_reset = 1'b0;
        din     = 1'b0;
        step();
        step();
        n_reset = 1'b1;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c;
        logic eo, ee;

        vecs[0]  = '{"nom10",   4, 10, 1'b1, 1'b0, 1'b1, 6'd10};
        vecs[1]  = '{"lo8",     4,  8, 1'b1, 1'b0, 1'b1, 6'd8};
        vecs[2]  = '{"hi12",    4, 12, 1'b1, 1'b0, 1'b1, 6'd12};
        vecs[3]  = '{"lo_m1",   4,  7, 1'b0, 1'b1, 1'b1, 6'd7};
        vecs[4]  = '{"hi_p1",   4, 13, 1'b0, 1'b1, 1'b1, 6'd13};
        vecs[5]  = '{"h0_sp2",  0,  2, 1'b1, 1'b0, 1'b1, 6'd2};
        vecs[6]  = '{"h0_sp5",  0,  5, 1'b0, 1'b1, 1'b1, 6'd5};
        vecs[7]  = '{"hmax32", 15, 32, 1'b1, 1'b0, 1'b1, 6'd32};
        vecs[8]  = '{"hmax29", 15, 29, 1'b0, 1'b1, 1'b1, 6'd29};
        vecs[9]  = '{"hmax35", 15, 35, 1'b0, 1'b1, 1'b1, 6'd35};
        vecs[10] = '{"tmo14",   4, 14, 1'b0, 1'b0, 1'b0, 6'd14};

        // Reset with a toggling input.
        h       = 4'd4;
        n_reset = 1'b0;
        din     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.out", 32'(out), 0);
            chk("rst.err", 32'(period_err), 0);
            chk("rst.last", 32'(last_period), 0);
            din = ~din;
        end
        n_reset = 1'b1;
        din     = 1'b0;
        step();
        chk("rel.out", 32'(out), 0);
        chk("rel.err", 32'(period_err), 0);
        chk("rel.last", 32'(last_period), 0);

        // Two rises at a fixed spacing per record, each record starting from reset.
        for (int i = 0; i < 11; i++) begin
            eo = CHK ? vecs[i].out_en : vecs[i].out_dis;
            ee = CHK ? vecs[i].err_en : 1'b0;
            reset_dut();
            h        = 4'(vecs[i].h);
            c        = cyc;
            err_seen = 0;
            expect_at(c + vecs[i].sp + 3, vecs[i].name, eo, ee, 1'b1, vecs[i].last);
            expect_at(c + vecs[i].sp + 4, {vecs[i].name, "+1"}, eo, 1'b0, 1'b1, vecs[i].last);
            gap(vecs[i].sp);
            gap(vecs[i].sp);
            repeat (4) step();
            chk({vecs[i].name, ".errcnt"}, 32'(err_seen), 32'(ee));
        end

        // Lock on a 5-high/5-low carrier, then let the burst end.
        reset_dut();
        h        = 4'd4;
        c        = cyc;
        err_seen = 0;
        expect_at(c + 12, "lock_pre", 1'b0, 1'b0, 1'b0, 6'd0);
        expect_at(c + 13, "lock_on", 1'b1, 1'b0, 1'b1, 6'd10);
        expect_at(c + 14, "lock_hold", 1'b1, 1'b0, 1'b1, 6'd10);
        expect_at(c + 45, "burst_hold", 1'b1, 1'b0, 1'b1, 6'd10);
        expect_at(c + 46, "burst_end", 1'b0, 1'b0, 1'b1, 6'd10);
        for (int p = 0; p < 4; p++) begin
            din = 1'b1;
            repeat (5) step();
            din = 1'b0;
            repeat (5) step();
        end
        repeat (10) step();
        chk("burst.errcnt", 32'(err_seen), 0);

        // A 6-cycle spacing while locked, then two rises spaced 10.
        reset_dut();
        h        = 4'd4;
        c        = cyc;
        err_seen = 0;
        expect_at(c + 13, "bad_lock", 1'b1, 1'b0, 1'b1, 6'd10);
        expect_at(c + 19, "bad_sp6", ~CHK, CHK, 1'b1, 6'd6);
        expect_at(c + 20, "bad_sp6+1", ~CHK, 1'b0, 1'b1, 6'd6);
        expect_at(c + 29, "bad_relock", 1'b1, 1'b0, 1'b1, 6'd10);
        gap(10);
        gap(6);
        gap(10);
        gap(10);
        chk("bad.errcnt", 32'(err_seen), 32'(CHK));

        // Reset while locked.
        reset_dut();
        h = 4'd4;
        c = cyc;
        expect_at(c + 13, "pre_rst", 1'b1, 1'b0, 1'b1, 6'd10);
        gap(10);
        gap(10);
        n_reset = 1'b0;
        step();
        chk("rst_mid.out", 32'(out), 0);
        chk("rst_mid.last", 32'(last_period), 0);
        n_reset = 1'b1;
        c = cyc;
        expect_at(c + 3, "relock1", 1'b0, 1'b0, 1'b0, 6'd0);
        expect_at(c + 13, "relock2", 1'b1, 1'b0, 1'b1, 6'd10);
        gap(10);
        gap(10);

        // Change H while locked: the next rise is judged against H=2.
        reset_dut();
        h        = 4'd4;
        c        = cyc;
        err_seen = 0;
        expect_at(c + 13, "hchg_lock", 1'b1, 1'b0, 1'b1, 6'd10);
        expect_at(c + 19, "hchg_new", 1'b1, 1'b0, 1'b1, 6'd6);
        gap(10);
        din = 1'b1;
        step();
        din = 1'b0;
        repeat (3) step();
        h = 4'd2;
        step();
        step();
        gap(6);
        chk("hchg.errcnt", 32'(err_seen), 0);

        // The interval counter saturates instead of wrapping.
        reset_dut();
        h = 4'd4;
        repeat (100) step();
        expect_at(cyc + 3, "sat", 1'b0, 1'b0, 1'b1, 6'd63);
        gap(5);

        chk("sb_drain", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
